// File: rtl/pipe_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
//
// Contents:
//   DATA_BUS_WIDTH       - default datapath width (32)
//   PIPE_RCA_DEF_STAGES  - default number of pipeline stages (4)
//   ovf_flag()           - signed overflow from the carries around the MSB
//
// Optional feature macro used by pipe_rca: PIPE_RCA_ZERO_FLAG_EN.
package pipe_rca_pkg;

    localparam int DATA_BUS_WIDTH      = 32;
    localparam int PIPE_RCA_DEF_STAGES = 4;

    // Two's-complement overflow: the carry into the sign bit disagrees
    // with the carry out of it.
    function automatic logic ovf_flag(input logic c_msb_in, input logic c_out);
        return c_msb_in ^ c_out;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//
// Ports:
//   a, b  in  operand bits
//   cin   in  carry in
//   s     out sum bit
//   cout  out carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry segment built from full_adder cells.
//
// Ports:
//   a, b      in  SEG-bit operand slices
//   cin       in  carry into bit 0
//   s         out SEG-bit partial sum
//   cout      out carry out of the top bit
//   c_msb_in  out carry into the top bit (used for signed overflow)
module rca_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb_in
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[SEG];
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor.
//
// A WIDTH-bit ripple chain is cut into STAGES segments of SEG = WIDTH/STAGES
// bits; stage k adds segment k and registers its partial sum and carry.
// One operation per cycle, valid/ready on both sides, no bubble collapsing:
// the whole pipe advances when the output is empty or being consumed.
//
// Ports:
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset (highest priority)
//   flush      in  synchronous kill of every in-flight operation
//   in_valid   in  input operation present
//   in_ready   out input accepted this cycle when in_valid is high
//   op1, op2   in  operands A and B
//   sub        in  1: A-B, 0: A+B+cin
//   cin        in  carry in (ignored when sub=1)
//   out_valid  out result present
//   out_ready  in  consumer takes the result
//   sum        out result, modulo 2^WIDTH
//   cout       out carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        out signed overflow
//   zero       out sum==0 (only when PIPE_RCA_ZERO_FLAG_EN is defined)
//
// Optional feature macro: PIPE_RCA_ZERO_FLAG_EN.
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH  = DATA_BUS_WIDTH,
    parameter int STAGES = PIPE_RCA_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef PIPE_RCA_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Replace segment k of a word with a freshly computed partial sum.
    function automatic logic [WIDTH-1:0] put_seg(input logic [WIDTH-1:0] w,
                                                 input logic [SEG-1:0]   s,
                                                 input int               k);
        logic [WIDTH-1:0] r;
        r = w;
        r[k*SEG +: SEG] = s;
        return r;
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Per-stage word: segments below k hold results, segments from k up
    // still hold operand A. B is carried separately, already conditioned.
    logic [WIDTH-1:0] w_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] w_nx  [STAGES];
    logic [SEG-1:0]   s_seg [STAGES];
    logic             co_seg[STAGES];
    logic             cm_seg[STAGES];

    logic [WIDTH-1:0] w_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic             c_p   [STAGES];
    logic             vld_p [STAGES];
    logic             ovf_p;

`ifdef PIPE_RCA_ZERO_FLAG_EN
    logic             z_in  [STAGES];
    logic             z_nx  [STAGES];
    logic             z_p   [STAGES];
`endif

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Input conditioning: subtract is A + ~B + 1.
    assign b_eff = sub ? ~op2 : op2;
    assign c0    = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_in[k] = op1;
            assign b_in[k] = b_eff;
            assign c_in[k] = c0;
`ifdef PIPE_RCA_ZERO_FLAG_EN
            assign z_in[k] = 1'b1;
`endif
        end else begin : g_next
            assign w_in[k] = w_p[k-1];
            assign b_in[k] = b_p[k-1];
            assign c_in[k] = c_p[k-1];
`ifdef PIPE_RCA_ZERO_FLAG_EN
            assign z_in[k] = z_p[k-1];
`endif
        end

        rca_seg #(.SEG(SEG)) u_seg (
            .a        (w_in[k][k*SEG +: SEG]),
            .b        (b_in[k][k*SEG +: SEG]),
            .cin      (c_in[k]),
            .s        (s_seg[k]),
            .cout     (co_seg[k]),
            .c_msb_in (cm_seg[k])
        );

        assign w_nx[k] = put_seg(w_in[k], s_seg[k], k);
`ifdef PIPE_RCA_ZERO_FLAG_EN
        // Running AND of per-segment zero tests rides along with the data.
        assign z_nx[k] = z_in[k] & (s_seg[k] == '0);
`endif
    end

    // ---- stage registers (stage k holds segment k's result) ----
    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                w_p[k] <= w_nx[k];
                b_p[k] <= b_in[k];
                c_p[k] <= co_seg[k];
`ifdef PIPE_RCA_ZERO_FLAG_EN
                z_p[k] <= z_nx[k];
`endif
            end
        end
        // Only the visible output registers are reset.
        if (rst) begin
            w_p[LAST] <= '0;
            c_p[LAST] <= 1'b0;
            ovf_p     <= 1'b0;
`ifdef PIPE_RCA_ZERO_FLAG_EN
            z_p[LAST] <= 1'b0;
`endif
        end else if (en) begin
            ovf_p <= ovf_flag(cm_seg[LAST], co_seg[LAST]);
        end
    end

    // ---- valid chain: reset and flush both drop everything in flight ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else if (en) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    assign out_valid = vld_p[LAST];
    assign sum       = w_p[LAST];
    assign cout      = c_p[LAST];
    assign ovf       = ovf_p;
`ifdef PIPE_RCA_ZERO_FLAG_EN
    assign zero      = z_p[LAST];
`endif

    // B bits below the current segment and the top-bit carries of inner
    // segments are structurally dead; collect them so they stay visible.
    logic unused_bits;
    always_comb begin
        unused_bits = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_bits = unused_bits ^ (^b_p[k]);
        end
        for (int k = 0; k < LAST; k++) begin
            unused_bits = unused_bits ^ cm_seg[k];
        end
    end

endmodule
